// File: rtl/smm0_pkg.sv
// Shared definitions for the small-matrix-multiply front end.
// Holds the default element width, the frame size and the loader state encoding.
package smm0_pkg;

  localparam int DATA_W_DEFAULT = 8;
  localparam int N_ELEM         = 8;

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_LOAD = 2'd1,
    ST_WAIT = 2'd2
  } loader_state_t;

endpackage

// File: rtl/smm0_in_loader.sv
// Operand loader for the 2x2 matrix multiplier.
// Collects eight streamed elements (A00..A11 then B00..B11), pulses load to the
// multiply controller, then holds the operands until the controller reports done.
module smm0_in_loader
  import smm0_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_data,
  input  logic                done,
  output logic                load,
  output logic [4*DATA_W-1:0] a_flat,
  output logic [4*DATA_W-1:0] b_flat,
  output logic [7:0]          frame_cnt
);

  loader_state_t     r_state;
  loader_state_t     w_nextState;
  logic [DATA_W-1:0] r_mem [N_ELEM];
  logic [2:0]        r_idx;
  logic [7:0]        r_frameCnt;
  logic              w_accept;
  logic              w_frameDone;

  // State register; reset always returns to FILL so any partial frame is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_FILL;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and handshake decode; in_ready depends only on the state.
  always_comb begin
    w_nextState = r_state;
    in_ready    = 1'b0;
    load        = 1'b0;
    w_accept    = 1'b0;
    w_frameDone = 1'b0;
    case (r_state)
      ST_FILL: begin
        in_ready = 1'b1;
        w_accept = in_valid;
        if (in_valid && (r_idx == 3'(N_ELEM - 1))) begin
          w_nextState = ST_LOAD;
        end
      end
      ST_LOAD: begin
        load        = 1'b1;
        w_nextState = ST_WAIT;
      end
      ST_WAIT: begin
        if (done) begin
          w_frameDone = 1'b1;
          w_nextState = ST_FILL;
        end
      end
      default: begin
        w_nextState = ST_FILL;
      end
    endcase
  end

  // Element storage and slot index; the 3-bit index wraps 7 -> 0 on the last element.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx <= 3'd0;
      for (int i = 0; i < N_ELEM; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_accept) begin
      r_mem[r_idx] <= in_data;
      r_idx        <= r_idx + 3'd1;
    end
  end

  // Completed-frame counter, advanced by the done pulse seen while waiting.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_frameCnt <= 8'd0;
    end else if (w_frameDone) begin
      r_frameCnt <= r_frameCnt + 8'd1;
    end
  end

  assign a_flat    = {r_mem[3], r_mem[2], r_mem[1], r_mem[0]};
  assign b_flat    = {r_mem[7], r_mem[6], r_mem[5], r_mem[4]};
  assign frame_cnt = r_frameCnt;

endmodule

// File: tb/tb_smm0_in_loader.sv
// Self-checking bench for smm0_in_loader: directed scenarios followed by
// randomized frames, all compared against a behavioural frame model.
module tb_smm0_in_loader;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          inValid;
  logic          inReady;
  logic [DW-1:0] inData;
  logic          done;
  logic          load;
  logic [4*DW-1:0] aFlat;
  logic [4*DW-1:0] bFlat;
  logic [7:0]    frameCnt;

  int vectors     = 0;
  int miscompares = 0;
  int loadSeen    = 0;

  // Behavioural model: elements collected so far, whether a load pulse is due,
  // whether we are waiting on the controller, and the completed-frame tally.
  logic [DW-1:0] mElem [8];
  int            mFill;
  bit            mLoadNext;
  bit            mWaiting;
  int            mFrames;

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  // Tally of load pulses so directed scenarios can confirm exactly one per frame.
  always @(posedge clk) begin
    if (load === 1'b1) loadSeen++;
  end

  smm0_in_loader #(.DATA_W(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (inValid),
    .in_ready (inReady),
    .in_data  (inData),
    .done     (done),
    .load     (load),
    .a_flat   (aFlat),
    .b_flat   (bFlat),
    .frame_cnt(frameCnt)
  );

  // Single comparison point: counts every check and reports any disagreement.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Clears the model the same way a reset clears the loader.
  task automatic modelReset();
    for (int i = 0; i < 8; i++) mElem[i] = '0;
    mFill     = 0;
    mLoadNext = 1'b0;
    mWaiting  = 1'b0;
    mFrames   = 0;
  endtask

  function automatic logic [31:0] expA();
    return {mElem[3], mElem[2], mElem[1], mElem[0]};
  endfunction

  function automatic logic [31:0] expB();
    return {mElem[7], mElem[6], mElem[5], mElem[4]};
  endfunction

  // Drives one cycle of inputs, checks the handshake outputs mid-cycle, advances
  // the model across the clock edge and checks the registered outputs after it.
  task automatic applyStimulus(input logic v, input logic [DW-1:0] d, input logic dn, input logic r);
    bit expReady;
    rst     = r;
    inValid = v;
    inData  = d;
    done    = dn;
    #1;
    expReady = !mLoadNext && !mWaiting;
    checkOutput("in_ready", {31'd0, inReady}, {31'd0, expReady});
    checkOutput("load", {31'd0, load}, {31'd0, mLoadNext});
    if (r) begin
      modelReset();
    end else if (expReady && v) begin
      mElem[mFill] = d;
      mFill++;
      if (mFill == 8) begin
        mFill     = 0;
        mLoadNext = 1'b1;
      end
    end else if (mLoadNext) begin
      mLoadNext = 1'b0;
      mWaiting  = 1'b1;
    end else if (mWaiting && dn) begin
      mWaiting = 1'b0;
      mFrames  = (mFrames + 1) % 256;
    end
    @(posedge clk);
    #1;
    checkOutput("a_flat", aFlat, expA());
    checkOutput("b_flat", bFlat, expB());
    checkOutput("frame_cnt", {24'd0, frameCnt}, mFrames);
  endtask

  // Main sequence: reset, directed scenarios, then 256 randomized frames.
  initial begin
    int startLoads;
    int target;
    int cycles;

    rst = 1'b1; inValid = 1'b0; inData = '0; done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    modelReset();
    checkOutput("rst_ready", {31'd0, inReady}, 32'd1);
    checkOutput("rst_load", {31'd0, load}, 32'd0);
    checkOutput("rst_a", aFlat, 32'd0);
    checkOutput("rst_cnt", {24'd0, frameCnt}, 32'd0);

    // Back-to-back frame 1..8; load must follow the 8th acceptance directly.
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    startLoads = loadSeen;
    for (int i = 1; i <= 8; i++) applyStimulus(1'b1, 8'(i), 1'b0, 1'b0);
    checkOutput("b2b_load", {31'd0, load}, 32'd1);
    checkOutput("b2b_ready", {31'd0, inReady}, 32'd0);
    checkOutput("b2b_a", aFlat, 32'h04030201);
    checkOutput("b2b_b", bFlat, 32'h08070605);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("b2b_loads", loadSeen - startLoads, 32'd1);
    applyStimulus(1'b1, 8'h33, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h44, 1'b0, 1'b0);

    // done together with valid in WAIT: not accepted that cycle, accepted the next.
    applyStimulus(1'b1, 8'h55, 1'b1, 1'b0);
    checkOutput("wait_cnt", {24'd0, frameCnt}, 32'd1);
    checkOutput("wait_a_hold", aFlat, 32'h04030201);
    applyStimulus(1'b1, 8'h55, 1'b0, 1'b0);
    checkOutput("wait_a00", {24'd0, aFlat[7:0]}, 32'h55);

    // Rest of that frame with valid toggling every other cycle.
    startLoads = loadSeen;
    for (int k = 2; k <= 8; k++) begin
      applyStimulus(1'b0, 8'hEE, 1'b0, 1'b0);
      applyStimulus(1'b1, 8'(k), 1'b0, 1'b0);
    end
    checkOutput("tog_a", aFlat, 32'h04030255);
    checkOutput("tog_b", bFlat, 32'h08070605);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("tog_loads", loadSeen - startLoads, 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("tog_cnt", {24'd0, frameCnt}, 32'd2);

    // done pulsed during FILL after three beats must be ignored.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("fill_done_cnt", {24'd0, frameCnt}, 32'd2);
    for (int i = 3; i < 8; i++) applyStimulus(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
    checkOutput("fill_done_a", aFlat, 32'h13121110);
    checkOutput("fill_done_b", bFlat, 32'h17161514);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);

    // Reset mid-frame, then a fresh frame 0xA0..0xA7 gives exactly one load.
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'(8'h90 + i), 1'b0, 1'b0);
    startLoads = loadSeen;
    applyStimulus(1'b1, 8'hFF, 1'b0, 1'b1);
    checkOutput("rst_mid_a", aFlat, 32'd0);
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("rst_mid_loads", loadSeen - startLoads, 32'd1);
    checkOutput("rst_mid_a2", aFlat, 32'hA3A2A1A0);

    // 256 randomized frames from reset; the counter must wrap back to zero.
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    for (int f = 0; f < 256; f++) begin
      target = (mFrames + 1) % 256;
      cycles = 0;
      while (mFrames != target && cycles < 200) begin
        applyStimulus(($urandom % 4) != 0, 8'($urandom), ($urandom % 5) == 0, 1'b0);
        cycles++;
      end
      checkOutput("frame_timeout", {31'd0, cycles < 200}, 32'd1);
    end
    checkOutput("wrap_cnt", {24'd0, frameCnt}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
